// File: rtl/match_scorekeeper.sv
// Match scorekeeper: latches points-to-win at start, tallies points, paces serves
// with a pause after each point and reports the winner at match end.
module match_scorekeeper #(
    parameter int unsigned SERVE_DELAY = 100000000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] max_score,
    input  logic       start,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [4:0] p1_score,
    output logic [4:0] p2_score,
    output logic [4:0] target,
    output logic       playing,
    output logic       serve_req,
    output logic       serve_side,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int unsigned SCORE_W = 5;
    localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(SERVE_DELAY - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [SCORE_W-1:0] p1_score_nx, p2_score_nx, target_nx;
    logic [SCORE_W-1:0] p1_inc, p2_inc;
    logic               playing_nx, serve_req_nx, serve_side_nx, game_over_nx;
    logic [1:0]         winner_nx;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            p1_score   <= '0;
            p2_score   <= '0;
            target     <= '0;
            playing    <= 1'b0;
            serve_req  <= 1'b0;
            serve_side <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            p1_score   <= p1_score_nx;
            p2_score   <= p2_score_nx;
            target     <= target_nx;
            playing    <= playing_nx;
            serve_req  <= serve_req_nx;
            serve_side <= serve_side_nx;
            game_over  <= game_over_nx;
            winner     <= winner_nx;
        end
    end

    assign p1_inc = p1_score + SCORE_W'(1);
    assign p2_inc = p2_score + SCORE_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        p1_score_nx   = p1_score;
        p2_score_nx   = p2_score;
        target_nx     = target;
        serve_req_nx  = 1'b0;
        serve_side_nx = serve_side;
        game_over_nx  = game_over;
        winner_nx     = winner;

        unique case (state)
            IDLE, OVER: begin
                if (start) begin
                    // A zero setting would end the match before it begins
                    target_nx     = (max_score == 5'd0) ? 5'd1 : max_score;
                    p1_score_nx   = '0;
                    p2_score_nx   = '0;
                    serve_side_nx = 1'b0;
                    serve_req_nx  = 1'b1;
                    game_over_nx  = 1'b0;
                    winner_nx     = 2'b00;
                    state_nx      = PLAY;
                end
            end
            PLAY: begin
                // Simultaneous pulses are a let and fall through unchanged
                if (p1_point && !p2_point) begin
                    p1_score_nx   = p1_inc;
                    serve_side_nx = 1'b0;
                    if (p1_inc == target) begin
                        game_over_nx = 1'b1;
                        winner_nx    = 2'b01;
                        state_nx     = OVER;
                    end else begin
                        cnt_nx   = PAUSE_LOAD;
                        state_nx = PAUSE;
                    end
                end else if (p2_point && !p1_point) begin
                    p2_score_nx   = p2_inc;
                    serve_side_nx = 1'b1;
                    if (p2_inc == target) begin
                        game_over_nx = 1'b1;
                        winner_nx    = 2'b10;
                        state_nx     = OVER;
                    end else begin
                        cnt_nx   = PAUSE_LOAD;
                        state_nx = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (cnt == '0) begin
                    serve_req_nx = 1'b1;
                    state_nx     = PLAY;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        playing_nx = (state_nx == PLAY);
    end

endmodule

// File: tb/tb_match_scorekeeper.sv
// Directed bench for match_scorekeeper with a short serve pause.
module tb_match_scorekeeper;

    localparam int unsigned SD = 4;

    logic       clk = 1'b0;
    logic       rst, start, p1_point, p2_point;
    logic [4:0] max_score;
    logic [4:0] p1_score, p2_score, target;
    logic       playing, serve_req, serve_side, game_over;
    logic [1:0] winner;

    int unsigned total_cnt  = 0;
    int unsigned passed_cnt = 0;

    match_scorekeeper #(.SERVE_DELAY(SD), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .max_score(max_score), .start(start),
        .p1_point(p1_point), .p2_point(p2_point),
        .p1_score(p1_score), .p2_score(p2_score), .target(target),
        .playing(playing), .serve_req(serve_req), .serve_side(serve_side),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic pulse_p1();
        p1_point = 1'b1; tick(); p1_point = 1'b0;
    endtask

    task automatic pulse_p2();
        p2_point = 1'b1; tick(); p2_point = 1'b0;
    endtask

    // Point edge already consumed; SD-1 quiet edges then the serve edge
    task automatic finish_pause(input string tag);
        repeat (SD - 1) tick();
        check({tag, "_quiet"}, 32'(serve_req), 0);
        tick();
        check({tag, "_serve"}, 32'(serve_req), 1);
        check({tag, "_play"}, 32'(playing), 1);
    endtask

    task automatic do_start(input logic [4:0] ms);
        max_score = ms; start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; p1_point = 1'b0; p2_point = 1'b0; max_score = 5'd0;
        tick(); tick();
        rst = 1'b0;
        check("rst_p1", 32'(p1_score), 0);
        check("rst_p2", 32'(p2_score), 0);
        check("rst_target", 32'(target), 0);
        check("rst_playing", 32'(playing), 0);
        check("rst_serve_req", 32'(serve_req), 0);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_winner", 32'(winner), 0);

        // Points in IDLE are ignored
        pulse_p1();
        check("idle_p1_ignored", 32'(p1_score), 0);

        do_start(5'd3);
        check("start_target", 32'(target), 3);
        check("start_playing", 32'(playing), 1);
        check("start_serve", 32'(serve_req), 1);
        check("start_winner", 32'(winner), 0);
        tick();
        check("start_serve_1cyc", 32'(serve_req), 0);

        pulse_p1();
        check("p1_score1", 32'(p1_score), 1);
        check("p1_side", 32'(serve_side), 0);
        check("p1_pause", 32'(playing), 0);
        // p2 pulse during the pause occupies the first pause edge
        pulse_p2();
        check("pause_p2_ignored", 32'(p2_score), 0);
        tick(); tick();
        check("pause_quiet", 32'(serve_req), 0);
        tick();
        check("pause_serve", 32'(serve_req), 1);
        check("pause_play", 32'(playing), 1);
        tick();
        check("serve_1cyc", 32'(serve_req), 0);

        p1_point = 1'b1; p2_point = 1'b1; tick(); p1_point = 1'b0; p2_point = 1'b0;
        check("let_p1", 32'(p1_score), 1);
        check("let_p2", 32'(p2_score), 0);
        check("let_playing", 32'(playing), 1);
        check("let_serve", 32'(serve_req), 0);

        do_start(5'd2);
        check("play_start_ignored", 32'(target), 3);

        pulse_p2();
        check("p2_side", 32'(serve_side), 1);
        finish_pause("m1a");
        pulse_p1();
        finish_pause("m1b");
        pulse_p1();
        check("m1_p1_win_score", 32'(p1_score), 3);
        check("m1_winner", 32'(winner), 1);
        check("m1_over", 32'(game_over), 1);

        do_start(5'd2);
        check("m2_target", 32'(target), 2);
        check("m2_p1_clear", 32'(p1_score), 0);
        check("m2_over_clear", 32'(game_over), 0);
        check("m2_winner_clear", 32'(winner), 0);
        check("m2_serve", 32'(serve_req), 1);
        pulse_p2();
        finish_pause("m2a");
        pulse_p1();
        check("m2_side_p1", 32'(serve_side), 0);
        finish_pause("m2b");
        pulse_p2();
        check("m2_p2_score", 32'(p2_score), 2);
        check("m2_over", 32'(game_over), 1);
        check("m2_winner", 32'(winner), 2);
        check("m2_no_serve", 32'(serve_req), 0);
        check("m2_not_playing", 32'(playing), 0);
        pulse_p1();
        repeat (SD + 1) tick();
        check("over_p1_hold", 32'(p1_score), 1);
        check("over_winner_hold", 32'(winner), 2);
        check("over_no_serve", 32'(serve_req), 0);

        do_start(5'd0);
        check("zero_target", 32'(target), 1);
        pulse_p1();
        check("zero_over", 32'(game_over), 1);
        check("zero_winner", 32'(winner), 1);
        do_start(5'd5);
        check("m4_target", 32'(target), 5);
        check("m4_p1_clear", 32'(p1_score), 0);
        check("m4_over_clear", 32'(game_over), 0);

        max_score = 5'd9;
        tick();
        pulse_p1();
        check("midmatch_max_no_effect", 32'(target), 5);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_p1", 32'(p1_score), 0);
        check("midrst_target", 32'(target), 0);
        check("midrst_playing", 32'(playing), 0);
        check("midrst_side", 32'(serve_side), 0);
        check("midrst_winner", 32'(winner), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_serve", 32'(serve_req), 0);
        end

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
